// File: rtl/rcv_uart.sv
// rcv_uart: configurable serial receiver with start-bit glitch rejection,
// 3-sample majority voting per bit and a show-ahead FIFO with sticky overrun.
module rcv_uart #(
   parameter int BIT_CLOCKS = 500,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 overrun,
   input  logic                 overrun_clr
);
   localparam int          PW        = $clog2(FIFO_DEPTH);
   localparam int          WW        = DATA_BITS + 2;
   localparam logic [15:0] HALF_M1   = 16'(BIT_CLOCKS / 2 - 1);
   localparam logic [15:0] FULL_M1   = 16'(BIT_CLOCKS - 1);
   localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_PUSH
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic [2:0]           v3_q, v3_d;
   logic                 armed_q, armed_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic [WW-1:0]        mem_q [FIFO_DEPTH];
   logic [WW-1:0]        mem_d [FIFO_DEPTH];
   logic [WW-1:0]        last_q, last_d;
   logic [PW:0]          wr_ptr_q, wr_ptr_d;
   logic [PW:0]          rd_ptr_q, rd_ptr_d;
   logic                 overrun_q, overrun_d;

   logic                 s;
   logic                 vote;
   logic                 tick;
   logic                 push;
   logic                 empty;
   logic                 full;
   logic                 pop;
   logic                 do_write;
   logic [WW-1:0]        head;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         v3_q      <= 3'b111;
         armed_q   <= 1'b0;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         last_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overrun_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         v3_q      <= v3_d;
         armed_q   <= armed_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         last_q    <= last_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         overrun_q <= overrun_d;
         mem_q     <= mem_d;
      end
   end

   always_comb begin
      sync1_d = serial_in;
      sync2_d = sync1_q;
      v3_d    = {v3_q[1:0], sync2_q};
   end

   assign s    = sync2_q;
   assign vote = (v3_q[0] & v3_q[1]) | (v3_q[0] & v3_q[2]) | (v3_q[1] & v3_q[2]);
   assign tick = (cnt_q == 16'd0);

   // After any frame (including a break) IDLE must see the line high before arming.
   always_comb begin
      state_d = state_q;
      armed_d = 1'b0;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      push    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            armed_d = armed_q | s;
            if (armed_q && !s) begin
               state_d = ST_START;
               cnt_d   = HALF_M1;
               armed_d = 1'b0;
            end
         end
         ST_START: begin
            if (!tick) begin
               cnt_d = cnt_q - 16'd1;
            end else if (vote) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DATA;
               cnt_d   = FULL_M1;
               bit_d   = '0;
               par_d   = 1'b0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         ST_DATA: begin
            if (!tick) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               cnt_d   = FULL_M1;
               shift_d = {vote, shift_q[DATA_BITS-1:1]};
               par_d   = par_q ^ vote;
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (!tick) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               cnt_d   = FULL_M1;
               perr_d  = (PARITY == 1) ? ~(par_q ^ vote) : (par_q ^ vote);
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (!tick) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               cnt_d = FULL_M1;
               if (!vote) begin
                  ferr_d = 1'b1;
               end
               if (bit_q == LAST_STOP) begin
                  state_d = ST_PUSH;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_PUSH: begin
            push    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign pop      = !empty && rx_ready;
   assign do_write = push && (!full || pop);

   // A simultaneous pop frees the slot being written, so a full FIFO still accepts.
   always_comb begin
      mem_d     = mem_q;
      last_d    = last_q;
      overrun_d = overrun_q;
      if (do_write) begin
         mem_d[wr_ptr_q[PW-1:0]] = {ferr_q, perr_q, shift_q};
      end
      if (pop) begin
         last_d = mem_q[rd_ptr_q[PW-1:0]];
      end
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, do_write};
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
      if (overrun_clr) begin
         overrun_d = 1'b0;
      end
      if (push && full && !pop) begin
         overrun_d = 1'b1;
      end
   end

   assign head          = empty ? last_q : mem_q[rd_ptr_q[PW-1:0]];
   assign rx_data       = head[DATA_BITS-1:0];
   assign rx_parity_err = head[DATA_BITS];
   assign rx_frame_err  = head[DATA_BITS+1];
   assign rx_valid      = !empty;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_rcv_uart.sv
// tb_rcv_uart: drives an 8N1 and a 7E2 receiver with directed and random frames;
// a queue-based reference model predicts every word popped from each FIFO.
module tb_rcv_uart;
   localparam int BC    = 16;
   localparam int H     = BC / 2;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } word_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] line;
   logic [1:0] ready;
   logic [1:0] clr;

   logic [7:0] rx_data0;
   logic       perr0, ferr0, valid0, ovr0;
   logic [6:0] rx_data1;
   logic       perr1, ferr1, valid1, ovr1;

   int    cyc = 0;
   int    n_checks = 0;
   int    n_pass = 0;
   int    last_e [2];
   int    rise0 = 0;
   int    hi_len0 = 0;
   logic  prev_valid0 = 1'b0;
   word_t exp_q0 [$];
   word_t exp_q1 [$];
   word_t w0, w1;

   rcv_uart #(.BIT_CLOCKS(BC), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .serial_in(line[0]), .rx_data(rx_data0),
      .rx_parity_err(perr0), .rx_frame_err(ferr0), .rx_valid(valid0), .rx_ready(ready[0]),
      .overrun(ovr0), .overrun_clr(clr[0]));

   rcv_uart #(.BIT_CLOCKS(BC), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .serial_in(line[1]), .rx_data(rx_data1),
      .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_valid(valid1), .rx_ready(ready[1]),
      .overrun(ovr1), .overrun_clr(clr[1]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed === expected) n_pass++;
      else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Sends one frame on a line, glitching one data-bit centre if glitch_bit >= 0;
   // the expected word is derived from the framing rules and queued up front.
   task automatic applyStimulus(input int dut, input logic [8:0] data, input logic flip_par,
                                input logic stop_val, input int glitch_bit, input logic expect_word);
      int         nbits, pmode, nstop;
      logic [8:0] d;
      logic       p;
      logic       bits [$];
      word_t      w;
      nbits = (dut == 0) ? 8 : 7;
      pmode = (dut == 0) ? 0 : 2;
      nstop = (dut == 0) ? 1 : 2;
      d = data & ((9'd1 << nbits) - 9'd1);
      p = (pmode == 1) ? ~(^d) : (^d);
      p = p ^ flip_par;
      bits.push_back(1'b0);
      for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
      if (pmode != 0) bits.push_back(p);
      for (int i = 0; i < nstop; i++) bits.push_back(stop_val);
      if (expect_word) begin
         w.data = d;
         w.perr = (pmode == 0) ? 1'b0 : ((pmode == 1) ? ~((^d) ^ p) : ((^d) ^ p));
         w.ferr = ~stop_val;
         if (dut == 0) begin
            if (exp_q0.size() < DEPTH) exp_q0.push_back(w);
         end else begin
            if (exp_q1.size() < DEPTH) exp_q1.push_back(w);
         end
      end
      last_e[dut] = cyc + 1;
      for (int b = 0; b < bits.size(); b++) begin
         for (int k = 0; k < BC; k++) begin
            line[dut] = (b == glitch_bit + 1 && k == H - 2) ? ~bits[b] : bits[b];
            @(negedge clk);
         end
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (reset_n && valid0) begin
         if (!prev_valid0) begin
            rise0   = cyc;
            hi_len0 = 1;
         end else begin
            hi_len0++;
         end
      end
      prev_valid0 = reset_n && valid0;
      if (reset_n && valid0 && ready[0]) begin
         checkOutput("dut0_word_expected", 32'(exp_q0.size() != 0), 1);
         if (exp_q0.size() != 0) begin
            w0 = exp_q0.pop_front();
            checkOutput("dut0_data", 32'(rx_data0), 32'(w0.data));
            checkOutput("dut0_perr", 32'(perr0), 32'(w0.perr));
            checkOutput("dut0_ferr", 32'(ferr0), 32'(w0.ferr));
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (reset_n && valid1 && ready[1]) begin
         checkOutput("dut1_word_expected", 32'(exp_q1.size() != 0), 1);
         if (exp_q1.size() != 0) begin
            w1 = exp_q1.pop_front();
            checkOutput("dut1_data", 32'(rx_data1), 32'(w1.data));
            checkOutput("dut1_perr", 32'(perr1), 32'(w1.perr));
            checkOutput("dut1_ferr", 32'(ferr1), 32'(w1.ferr));
         end
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: time limit exceeded before summary");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int tgt;
      reset_n = 1'b0;
      line    = 2'b11;
      ready   = 2'b00;
      clr     = 2'b00;
      repeat (3) @(negedge clk);
      checkOutput("rst_valid0", valid0, 0);
      checkOutput("rst_ovr0", ovr0, 0);
      checkOutput("rst_data0", rx_data0, 0);
      checkOutput("rst_perr0", perr0, 0);
      checkOutput("rst_ferr0", ferr0, 0);
      checkOutput("rst_valid1", valid1, 0);
      checkOutput("rst_ovr1", ovr1, 0);
      checkOutput("rst_data1", rx_data1, 0);
      checkOutput("rst_perr1", perr1, 0);
      checkOutput("rst_ferr1", ferr1, 0);
      reset_n = 1'b1;
      ready   = 2'b11;
      repeat (4) @(negedge clk);

      $display("[TB] 8N1 0xA5 with latency");
      applyStimulus(0, 9'h0A5, 1'b0, 1'b1, -1, 1'b1);
      // first line-low edge -> s two edges later -> H to start centre -> 9 bit pitches -> push -> valid
      checkOutput("latency_8n1", rise0 - last_e[0], H + 2 + 9 * BC + 1);
      checkOutput("valid_width", hi_len0, 1);

      $display("[TB] 7E2 parity good then bad");
      applyStimulus(1, 9'h035, 1'b0, 1'b1, -1, 1'b1);
      applyStimulus(1, 9'h035, 1'b1, 1'b1, -1, 1'b1);
      repeat (BC) @(negedge clk);
      checkOutput("dut1_after_parity", exp_q1.size(), 0);

      $display("[TB] start glitch then 0x3C");
      line[0] = 1'b0;
      repeat (3) @(negedge clk);
      line[0] = 1'b1;
      repeat (2 * BC) @(negedge clk);
      applyStimulus(0, 9'h03C, 1'b0, 1'b1, -1, 1'b1);
      repeat (BC) @(negedge clk);
      checkOutput("dut0_after_glitch", exp_q0.size(), 0);

      $display("[TB] break then 0x11");
      applyStimulus(0, 9'h000, 1'b0, 1'b0, -1, 1'b1);
      repeat (40 * BC) @(negedge clk);
      line[0] = 1'b1;
      repeat (2 * BC) @(negedge clk);
      applyStimulus(0, 9'h011, 1'b0, 1'b1, -1, 1'b1);
      repeat (BC) @(negedge clk);
      checkOutput("dut0_after_break", exp_q0.size(), 0);

      $display("[TB] overrun");
      ready[0] = 1'b0;
      for (int i = 1; i <= 5; i++) applyStimulus(0, 9'(i), 1'b0, 1'b1, -1, 1'b1);
      checkOutput("ovr_after_5th", ovr0, 1);
      checkOutput("fifo_full_valid", valid0, 1);
      fork
         applyStimulus(0, 9'd6, 1'b0, 1'b1, -1, 1'b1);
         begin
            @(negedge clk);
            clr[0] = 1'b1;
            @(negedge clk);
            clr[0] = 1'b0;
            checkOutput("ovr_cleared", ovr0, 0);
            tgt = last_e[0] + H + 2 + 9 * BC;
            while (cyc < tgt) @(negedge clk);
            clr[0] = 1'b1;
            @(negedge clk);
            clr[0] = 1'b0;
            checkOutput("ovr_set_wins", ovr0, 1);
         end
      join
      ready[0] = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("dut0_drained", exp_q0.size(), 0);
      checkOutput("dut0_empty", valid0, 0);
      clr[0] = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0;
      checkOutput("ovr_final_clear", ovr0, 0);

      $display("[TB] data-bit centre glitches");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 9'($urandom), 1'b0, 1'b1, $urandom_range(0, 7), 1'b1);
      end
      repeat (BC) @(negedge clk);
      checkOutput("dut0_after_vote", exp_q0.size(), 0);

      $display("[TB] reset mid-frame");
      ready[1] = 1'b0;
      applyStimulus(1, 9'h02A, 1'b0, 1'b1, -1, 1'b1);
      repeat (BC) @(negedge clk);
      checkOutput("pre_reset_valid", valid1, 1);
      line[1] = 1'b0;
      repeat (4 * BC) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("mid_reset_valid", valid1, 0);
      checkOutput("mid_reset_data", rx_data1, 0);
      checkOutput("mid_reset_ovr", ovr1, 0);
      exp_q0.delete();
      exp_q1.delete();
      line[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset_n  = 1'b1;
      ready[1] = 1'b1;
      repeat (2 * BC) @(negedge clk);
      checkOutput("post_reset_valid", valid1, 0);
      applyStimulus(1, 9'($urandom), 1'b0, 1'b1, -1, 1'b1);
      repeat (BC) @(negedge clk);
      checkOutput("dut1_after_reset", exp_q1.size(), 0);

      $display("[TB] random traffic");
      fork
         for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 9'($urandom), 1'b0, 1'b1,
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1, 1'b1);
            repeat ($urandom_range(0, 20)) @(negedge clk);
         end
         for (int i = 0; i < 10; i++) begin
            logic bad_stop;
            bad_stop = ($urandom_range(0, 3) == 0);
            applyStimulus(1, 9'($urandom), 1'($urandom_range(0, 1)), ~bad_stop, -1, 1'b1);
            line[1] = 1'b1;
            repeat (bad_stop ? BC : $urandom_range(0, 20)) @(negedge clk);
         end
      join
      repeat (2 * BC) @(negedge clk);
      checkOutput("dut0_final_left", exp_q0.size(), 0);
      checkOutput("dut1_final_left", exp_q1.size(), 0);
      checkOutput("dut0_final_ovr", ovr0, 0);
      checkOutput("dut1_final_ovr", ovr1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
